// File: rtl/mem_bus_target.sv
// Purpose: CPU bus target with a RAM, a 4-entry output byte FIFO, status/overflow
//          reporting and an optional free-running timer with a high-byte snapshot.
// Latency: reads are combinational (0 cycles); writes, pushes and pops take effect at
//          the rising clock edge.
// Backpressure: io_valid/io_ready handshake on the FIFO head. A push into a full FIFO
//               is accepted only if a pop happens at the same edge; otherwise it is
//               dropped and the sticky ovf flag is set.
//
// Ports:
//   clk_in, reset_in        clock, synchronous active-high reset
//   bus_addr/bus_wdata      CPU address and write data
//   ram_wr/ram_oe           CPU write enable / read enable (write wins)
//   bus_rdata               combinational read data (0x00 when not reading)
//   io_data/io_valid/io_ready  FIFO head byte, non-empty flag, downstream accept
//   stage_dbg               FIFO occupancy 0..4
//
// Build option: define MEM_BUS_TARGET_TIMER_EN to include the timer and the
// TMR_L/TMR_H registers; without it 0xFF02/0xFF03 read as unmapped (0xFF).

module mem_bus_target #(
   parameter int RAM_AW = 12
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic [15:0] bus_addr,
   input  logic [7:0]  bus_wdata,
   output logic [7:0]  bus_rdata,
   input  logic        ram_wr,
   input  logic        ram_oe,
   output logic [7:0]  io_data,
   output logic        io_valid,
   input  logic        io_ready,
   output logic [2:0]  stage_dbg
);

   localparam logic [15:0] ADDR_IO_DATA = 16'hFF00;
   localparam logic [15:0] ADDR_STATUS  = 16'hFF01;
`ifdef MEM_BUS_TARGET_TIMER_EN
   localparam logic [15:0] ADDR_TMR_L   = 16'hFF02;
   localparam logic [15:0] ADDR_TMR_H   = 16'hFF03;
`endif

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   logic [7:0] r_ram [0:(1 << RAM_AW) - 1];

   logic [7:0] r_fifo [0:3];
   logic [1:0] r_wp;
   logic [1:0] r_rp;
   logic [2:0] r_cnt;
   logic       r_ovf;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic w_hit_ram;
   logic w_hit_iod;
   logic w_hit_stat;
   logic w_rd;

   // RAM occupies everything whose bits above RAM_AW are zero.
   assign w_hit_ram  = ((32'(bus_addr) >> RAM_AW) == 32'd0);
   assign w_hit_iod  = (bus_addr == ADDR_IO_DATA);
   assign w_hit_stat = (bus_addr == ADDR_STATUS);
   // A write cycle suppresses the read path entirely (no read side effects).
   assign w_rd       = ram_oe & ~ram_wr;

   // ------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------
   logic w_push;
   logic w_pop;
   logic w_full;
   logic w_empty;
   logic w_accept;
   logic w_drop;
   logic w_stat_wr;

   assign w_full    = (r_cnt == 3'd4);
   assign w_empty   = (r_cnt == 3'd0);
   assign w_push    = ram_wr & w_hit_iod;
   assign w_pop     = io_ready & ~w_empty;
   // When full, a simultaneous pop frees the slot the write pointer already
   // points at (wp == rp), so the push can land there at the same edge.
   assign w_accept  = w_push & (~w_full | w_pop);
   assign w_drop    = w_push & w_full & ~w_pop;
   assign w_stat_wr = ram_wr & w_hit_stat;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_wp  <= 2'd0;
         r_rp  <= 2'd0;
         r_cnt <= 3'd0;
         r_ovf <= 1'b0;
      end else begin
         if (w_accept) begin
            r_fifo[r_wp] <= bus_wdata;
            r_wp         <= r_wp + 2'd1;
         end
         if (w_pop) begin
            r_rp <= r_rp + 2'd1;
         end
         case ({w_accept, w_pop})
            2'b10:   r_cnt <= r_cnt + 3'd1;
            2'b01:   r_cnt <= r_cnt - 3'd1;
            default: r_cnt <= r_cnt;
         endcase
         // Overflow set has priority over a clear from a STATUS write.
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (w_stat_wr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign io_valid  = ~w_empty;
   assign io_data   = r_fifo[r_rp];
   assign stage_dbg = r_cnt;

   // ------------------------------------------------------------------
   // RAM write port (contents survive reset; reset only blocks the write)
   // ------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (!reset_in && ram_wr && w_hit_ram) begin
         r_ram[bus_addr[RAM_AW-1:0]] <= bus_wdata;
      end
   end

`ifdef MEM_BUS_TARGET_TIMER_EN
   // ------------------------------------------------------------------
   // Free-running timer with high-byte snapshot taken on a TMR_L read,
   // so a TMR_L then TMR_H sequence yields a coherent 16-bit value.
   // ------------------------------------------------------------------
   logic [15:0] r_tmr;
   logic [7:0]  r_shadow;
   logic        w_hit_tl;
   logic        w_hit_th;

   assign w_hit_tl = (bus_addr == ADDR_TMR_L);
   assign w_hit_th = (bus_addr == ADDR_TMR_H);

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_tmr    <= 16'd0;
         r_shadow <= 8'd0;
      end else begin
         r_tmr <= r_tmr + 16'd1;
         if (w_rd && w_hit_tl) begin
            r_shadow <= r_tmr[15:8];
         end
      end
   end
`endif

   // ------------------------------------------------------------------
   // Combinational read mux
   // ------------------------------------------------------------------
   always_comb begin
      bus_rdata = 8'h00;
      if (w_rd) begin
         if (w_hit_ram) begin
            bus_rdata = r_ram[bus_addr[RAM_AW-1:0]];
         end else if (w_hit_iod) begin
            bus_rdata = {5'b0, r_cnt};
         end else if (w_hit_stat) begin
            bus_rdata = {5'b0, r_ovf, w_empty, w_full};
`ifdef MEM_BUS_TARGET_TIMER_EN
         end else if (w_hit_tl) begin
            bus_rdata = r_tmr[7:0];
         end else if (w_hit_th) begin
            bus_rdata = r_shadow;
`endif
         end else begin
            bus_rdata = 8'hFF;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_target.sv
// Purpose: self-checking bench for mem_bus_target using a queue/array reference model
//          plus directed scenarios with literal expectations.
// Latency: model advances at each rising edge; outputs compared at each falling edge.
// Backpressure: io_ready is driven directly by the stimulus to exercise stall and drain.

module tb_mem_bus_target;

   logic        clk_in;
   logic        reset_in;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic        ram_wr;
   logic        ram_oe;
   logic [7:0]  io_data;
   logic        io_valid;
   logic        io_ready;
   logic [2:0]  stage_dbg;

   int n_checks = 0;
   int n_errors = 0;

   mem_bus_target #(.RAM_AW(12)) dut (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .ram_wr    (ram_wr),
      .ram_oe    (ram_oe),
      .io_data   (io_data),
      .io_valid  (io_valid),
      .io_ready  (io_ready),
      .stage_dbg (stage_dbg)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: FIFO as a queue, RAM as a sparse array.
   // ------------------------------------------------------------------
   logic [7:0] m_q [$];
   logic [7:0] m_ram [int];
   logic       m_ovf   = 1'b0;
   logic       m_valid = 1'b0;
`ifdef MEM_BUS_TARGET_TIMER_EN
   logic [15:0] m_tmr    = 16'd0;
   logic [7:0]  m_shadow = 8'd0;
`endif

   always @(posedge clk_in) begin
      int  sz;
      logic push, pop, ovf_set;
      if (reset_in) begin
         m_q.delete();
         m_ovf   = 1'b0;
         m_valid = 1'b1;
`ifdef MEM_BUS_TARGET_TIMER_EN
         m_tmr    = 16'd0;
         m_shadow = 8'd0;
`endif
      end else if (m_valid) begin
         sz      = m_q.size();
         push    = ram_wr && (bus_addr == 16'hFF00);
         pop     = io_ready && (sz > 0);
         ovf_set = 1'b0;
         if (pop) void'(m_q.pop_front());
         if (push) begin
            if (sz < 4 || pop) m_q.push_back(bus_wdata);
            else ovf_set = 1'b1;
         end
         if (ovf_set) m_ovf = 1'b1;
         else if (ram_wr && bus_addr == 16'hFF01) m_ovf = 1'b0;
         if (ram_wr && bus_addr < 16'h1000) m_ram[int'(bus_addr)] = bus_wdata;
`ifdef MEM_BUS_TARGET_TIMER_EN
         if (ram_oe && !ram_wr && bus_addr == 16'hFF02) m_shadow = m_tmr[15:8];
         m_tmr = m_tmr + 16'd1;
`endif
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk_in) begin
      logic [7:0] exp_rd;
      logic       skip;
      if (m_valid) begin
         exp_rd = 8'h00;
         skip   = 1'b0;
         if (ram_oe && !ram_wr) begin
            if (bus_addr < 16'h1000) begin
               if (m_ram.exists(int'(bus_addr))) exp_rd = m_ram[int'(bus_addr)];
               else skip = 1'b1;
            end else if (bus_addr == 16'hFF00) begin
               exp_rd = 8'(m_q.size());
            end else if (bus_addr == 16'hFF01) begin
               exp_rd = {5'b0, m_ovf, m_q.size() == 0, m_q.size() == 4};
`ifdef MEM_BUS_TARGET_TIMER_EN
            end else if (bus_addr == 16'hFF02) begin
               exp_rd = m_tmr[7:0];
            end else if (bus_addr == 16'hFF03) begin
               exp_rd = m_shadow;
`endif
            end else begin
               exp_rd = 8'hFF;
            end
         end
         if (!skip) chk("model_rdata", 16'(bus_rdata), 16'(exp_rd));
         chk("model_io_valid", 16'(io_valid), 16'(m_q.size() != 0));
         chk("model_stage_dbg", 16'(stage_dbg), 16'(m_q.size()));
         if (m_q.size() != 0) chk("model_io_data", 16'(io_data), 16'(m_q[0]));
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after the rising edge)
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      bus_addr  = a;
      bus_wdata = d;
      ram_wr    = 1'b1;
      ram_oe    = 1'b0;
      tick();
      ram_wr    = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [7:0] e, input string nm);
      bus_addr = a;
      ram_oe   = 1'b1;
      ram_wr   = 1'b0;
      @(negedge clk_in);
      chk(nm, 16'(bus_rdata), 16'(e));
      tick();
      ram_oe   = 1'b0;
   endtask

   logic [7:0] drain_exp [4];

   initial begin
      drain_exp = '{8'h22, 8'h33, 8'h44, 8'h66};
      reset_in  = 1'b1;
      bus_addr  = 16'h0000;
      bus_wdata = 8'h00;
      ram_wr    = 1'b0;
      ram_oe    = 1'b0;
      io_ready  = 1'b0;
      repeat (2) tick();
      reset_in  = 1'b0;

      // Reset state
      @(negedge clk_in);
      chk("reset_stage_dbg", 16'(stage_dbg), 16'h0);
      chk("reset_io_valid", 16'(io_valid), 16'h0);
      chk("reset_rdata_idle", 16'(bus_rdata), 16'h0);
      tick();

      // RAM write/read, unmapped, boundaries
      wr(16'h0010, 8'hA5);
      rd(16'h0010, 8'hA5, "ram_rd_0010");
      rd(16'h2000, 8'hFF, "unmapped_rd_2000");
      wr(16'h0FFF, 8'h3C);
      rd(16'h0FFF, 8'h3C, "ram_rd_top");
      rd(16'h1000, 8'hFF, "unmapped_rd_1000");
      wr(16'h3000, 8'h12);
      rd(16'h3000, 8'hFF, "unmapped_wr_ignored");
      wr(16'hFF04, 8'h34);
      rd(16'hFF04, 8'hFF, "unmapped_rd_ff04");
      bus_addr = 16'h0010;
      @(negedge clk_in);
      chk("rdata_oe0", 16'(bus_rdata), 16'h0);
      tick();

      // Fill FIFO with no drain, then overflow
      wr(16'hFF00, 8'h11);
      wr(16'hFF00, 8'h22);
      wr(16'hFF00, 8'h33);
      wr(16'hFF00, 8'h44);
      @(negedge clk_in);
      chk("full_stage_dbg", 16'(stage_dbg), 16'h4);
      tick();
      rd(16'hFF01, 8'h01, "status_full");
      wr(16'hFF00, 8'h55);
      rd(16'hFF01, 8'h05, "status_full_ovf");
      @(negedge clk_in);
      chk("head_after_ovf", 16'(io_data), 16'h11);
      tick();

      // Push while full with simultaneous pop
      io_ready = 1'b1;
      wr(16'hFF00, 8'h66);
      io_ready = 1'b0;
      rd(16'hFF00, 8'h04, "count_after_pushpop");
      rd(16'hFF01, 8'h05, "ovf_unchanged");

      // Drain
      io_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_in);
         chk("drain_data", 16'(io_data), 16'(drain_exp[i]));
         tick();
      end
      io_ready = 1'b0;
      @(negedge clk_in);
      chk("drained_io_valid", 16'(io_valid), 16'h0);
      tick();

      // STATUS write clears ovf; write+read at IO_DATA pushes only
      wr(16'hFF01, 8'h00);
      rd(16'hFF01, 8'h02, "status_cleared");
      bus_addr  = 16'hFF00;
      bus_wdata = 8'h77;
      ram_wr    = 1'b1;
      ram_oe    = 1'b1;
      @(negedge clk_in);
      chk("wr_oe_rdata_zero", 16'(bus_rdata), 16'h0);
      tick();
      ram_wr = 1'b0;
      ram_oe = 1'b0;
      @(negedge clk_in);
      chk("wr_oe_pushed", 16'(stage_dbg), 16'h1);
      tick();

      // Pop the last byte, then io_ready while empty has no effect
      io_ready = 1'b1;
      repeat (3) tick();
      io_ready = 1'b0;
      @(negedge clk_in);
      chk("empty_ready_no_effect", 16'(stage_dbg), 16'h0);
      tick();

      // Reset with three entries queued and a simultaneous RAM write
      wr(16'hFF00, 8'hA1);
      wr(16'hFF00, 8'hA2);
      wr(16'hFF00, 8'hA3);
      @(negedge clk_in);
      chk("pre_reset_count", 16'(stage_dbg), 16'h3);
      tick();
      reset_in  = 1'b1;
      bus_addr  = 16'h0010;
      bus_wdata = 8'h5A;
      ram_wr    = 1'b1;
      tick();
      reset_in  = 1'b0;
      ram_wr    = 1'b0;
      @(negedge clk_in);
      chk("post_reset_io_valid", 16'(io_valid), 16'h0);
      chk("post_reset_stage_dbg", 16'(stage_dbg), 16'h0);
      tick();
      rd(16'h0010, 8'hA5, "ram_survives_reset");

`ifdef MEM_BUS_TARGET_TIMER_EN
      // Timer: after reset edge the timer is 0, then +1 per edge.
      reset_in = 1'b1;
      tick();
      reset_in = 1'b0;
      repeat (255) tick();
      rd(16'hFF02, 8'hFF, "tmr_l_00ff");
      rd(16'hFF03, 8'h00, "tmr_h_shadow");
      rd(16'hFF02, 8'h01, "tmr_l_0101");
      rd(16'hFF03, 8'h01, "tmr_h_shadow2");
`else
      rd(16'hFF02, 8'hFF, "tmr_l_unmapped");
      rd(16'hFF03, 8'hFF, "tmr_h_unmapped");
`endif

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
